// File: rtl/sseg_dev.sv
`timescale 1ns/1ps
// Serial driver for an 8-digit seven-segment display behind a 64-bit shift chain.
// A Start rising edge latches a decoded active-low frame and shifts it out MSB first.
module sseg_dev #(
  parameter int SCLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        flash,
  input  logic [31:0] Hexs,
  input  logic [7:0]  point,
  input  logic [7:0]  LES,
  output logic        seg_clk,
  output logic        seg_clrn,
  output logic        seg_sout,
  output logic        SEG_PEN
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);

  state_t        state_q, state_d;
  logic [63:0]   frame_q, frame_d;
  logic [CW-1:0] half_q, half_d;
  logic [5:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          pen_q, pen_d;
  logic          clrn_q;
  logic          start_prev_q;
  logic          trigger;
  logic [63:0]   frame_new;

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign frame_new[8*gi +: 8] = (LES[gi] && flash) ? 8'hFF
                                  : {~point[gi], hex_to_seg(Hexs[4*gi +: 4])};
    end
  endgenerate

  assign trigger = Start & ~start_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_q      <= '1;
      half_q       <= '0;
      bit_q        <= '0;
      sclk_q       <= 1'b0;
      pen_q        <= 1'b0;
      clrn_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      sclk_q       <= sclk_d;
      pen_q        <= pen_d;
      clrn_q       <= 1'b1;
      start_prev_q <= Start;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    half_d  = half_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    pen_d   = pen_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_SHIFT;
          frame_d = frame_new;
          half_d  = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          pen_d   = 1'b0;
        end
      end
      default: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 6'd63) begin
            // Idle line level is all ones, so seg_sout rests high.
            state_d = S_IDLE;
            sclk_d  = 1'b0;
            frame_d = '1;
            pen_d   = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            bit_d   = bit_q + 6'd1;
            frame_d = {frame_q[62:0], 1'b1};
          end
        end else begin
          half_d = half_q + CW'(1);
        end
      end
    endcase
  end

  assign seg_clk  = sclk_q;
  assign seg_clrn = clrn_q;
  assign seg_sout = frame_q[63];
  assign SEG_PEN  = pen_q;

endmodule

// File: tb/tb_sseg_dev.sv
`timescale 1ns/1ps
// Bench for sseg_dev: captures serial frames on seg_clk rises and compares them
// with a digit-by-digit table model of the display encoding.
module tb_sseg_dev;

  logic        clk = 1'b0;
  logic        rst, Start, flash;
  logic [31:0] Hexs;
  logic [7:0]  point, LES;
  logic        seg_clk, seg_clrn, seg_sout, SEG_PEN;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  sseg_dev #(.SCLK_HALF(1)) dut (
    .clk(clk), .rst(rst), .Start(Start), .flash(flash), .Hexs(Hexs),
    .point(point), .LES(LES), .seg_clk(seg_clk), .seg_clrn(seg_clrn),
    .seg_sout(seg_sout), .SEG_PEN(SEG_PEN)
  );

  function automatic logic [63:0] model(input logic [31:0] h, input logic [7:0] p,
                                        input logic [7:0] les, input logic f);
    logic [63:0] fr;
    logic [7:0]  b;
    logic [3:0]  nib;
    fr = '0;
    for (int d = 7; d >= 0; d--) begin
      nib  = h[4*d +: 4];
      b    = seg_tbl[nib];
      b[7] = ~p[d];
      if (les[d] && f) b = 8'hFF;
      fr = {fr[55:0], b};
    end
    return fr;
  endfunction

  // Pulses Start (held for 'hold' cycles), captures bits on seg_clk rises until SEG_PEN.
  // poke_kind 1: extra Start edge after rise poke_rise; 2: assert rst after rise poke_rise.
  task automatic run_frame(input int hold, input int poke_rise, input int poke_kind,
                           input bit scramble, output logic [63:0] got,
                           output int rises, output int lat);
    bit prev;
    bit drop;
    prev = 1'b0; drop = 1'b0;
    got = '0; rises = 0; lat = -1;
    @(posedge clk); #1 Start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == hold) Start = 1'b0;
      if (drop) begin Start = 1'b0; drop = 1'b0; end
      if (scramble && c == 4) begin
        Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
      end
      if (seg_clk && !prev) begin
        got = {got[62:0], seg_sout};
        rises++;
        if (rises == poke_rise && poke_kind == 1) begin Start = 1'b1; drop = 1'b1; end
        if (rises == poke_rise && poke_kind == 2) begin rst = 1'b1; break; end
      end
      prev = seg_clk;
      if (SEG_PEN) begin lat = c; break; end
    end
  endtask

  task automatic check_frame(input string name, input logic [63:0] got, input logic [63:0] exp,
                             input int rises, input int lat);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s frame: got %h expected %h", name, got, exp);
    end
    checks++;
    if (rises !== 64) begin
      errors++; $display("FAIL %s rises: got %0d expected 64", name, rises);
    end
    checks++;
    if (lat !== 129) begin
      errors++; $display("FAIL %s latency: got %0d expected 129", name, lat);
    end
    checks++;
    if (seg_clk !== 1'b0 || seg_sout !== 1'b1 || SEG_PEN !== 1'b1) begin
      errors++;
      $display("FAIL %s idle outputs: clk=%b sout=%b pen=%b expected 0 1 1", name, seg_clk, seg_sout, SEG_PEN);
    end
    $display("frame %s: got %h expected %h rises=%0d latency=%0d", name, got, exp, rises, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; flash = 1'b0; Hexs = '0; point = '0; LES = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({seg_clk, seg_clrn, seg_sout, SEG_PEN} !== 4'b0010) begin
      errors++;
      $display("FAIL reset outputs: got clk/clrn/sout/pen=%b%b%b%b expected 0010", seg_clk, seg_clrn, seg_sout, SEG_PEN);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (seg_clrn !== 1'b0) begin
      errors++; $display("FAIL clrn before edge: got %b expected 0", seg_clrn);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (seg_clrn !== 1'b1 || SEG_PEN !== 1'b0) begin
      errors++; $display("FAIL clrn release: got clrn=%b pen=%b expected 1 0", seg_clrn, SEG_PEN);
    end
    $display("reset: clrn=%b pen=%b", seg_clrn, SEG_PEN);
  endtask

  task automatic test_fixed_patterns();
    logic [63:0] got, exp;
    int rises, lat;
    Hexs = 32'h0500_0003; point = 8'h41; LES = 8'h00; flash = 1'b1;
    run_frame(1, 0, 0, 1'b0, got, rises, lat);
    check_frame("digits_dp", got, 64'hC012_C0C0_C0C0_C030, rises, lat);
    Hexs = 32'h89AB_CDEF; point = 8'h00; LES = 8'h00;
    run_frame(1, 0, 0, 1'b0, got, rises, lat);
    check_frame("hex_upper", got, 64'h8090_8883_C6A1_868E, rises, lat);
    Hexs = 32'h1111_1111; LES = 8'h0F; flash = 1'b1;
    run_frame(1, 0, 0, 1'b0, got, rises, lat);
    check_frame("blink_on", got, 64'hF9F9_F9F9_FFFF_FFFF, rises, lat);
    flash = 1'b0;
    run_frame(1, 0, 0, 1'b0, got, rises, lat);
    exp = {8{8'hF9}};
    check_frame("blink_off", got, exp, rises, lat);
  endtask

  task automatic test_random_frames();
    logic [63:0] got, exp;
    int rises, lat;
    for (int n = 0; n < 6; n++) begin
      Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
      exp = model(Hexs, point, LES, flash);
      run_frame(1, 0, 0, 1'b1, got, rises, lat);
      check_frame("random", got, exp, rises, lat);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
  endtask

  task automatic test_busy_start();
    logic [63:0] got, exp;
    int rises, lat, extra;
    Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
    exp = model(Hexs, point, LES, flash);
    run_frame(1, 20, 1, 1'b0, got, rises, lat);
    check_frame("busy_start", got, exp, rises, lat);
    extra = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (seg_clk || !SEG_PEN) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL busy_queue: got %0d active cycles after frame expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    int rises, lat, active;
    Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
    run_frame(1, 30, 2, 1'b0, got, rises, lat);
    #1;
    checks++;
    if (rises !== 30 || {seg_clk, seg_clrn, seg_sout, SEG_PEN} !== 4'b0010) begin
      errors++;
      $display("FAIL abort outputs: rises=%0d clk/clrn/sout/pen=%b%b%b%b expected 30 0010",
               rises, seg_clk, seg_clrn, seg_sout, SEG_PEN);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    active = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (seg_clk || SEG_PEN || !seg_sout) active++;
    end
    checks++;
    if (active !== 0) begin
      errors++; $display("FAIL abort idle: got %0d active cycles expected 0", active);
    end
    $display("reset_mid: aborted at rise %0d", rises);
    run_frame(1, 0, 0, 1'b0, got, rises, lat);
    check_frame("after_abort", got, model(Hexs, point, LES, flash), rises, lat);
  endtask

  task automatic test_start_held();
    logic [63:0] got, exp;
    int rises, lat, extra;
    Hexs = $urandom; point = 8'($urandom); LES = 8'($urandom); flash = 1'($urandom);
    exp = model(Hexs, point, LES, flash);
    run_frame(1000, 0, 0, 1'b0, got, rises, lat);
    check_frame("start_held", got, exp, rises, lat);
    extra = 0;
    for (int c = lat; c < 1000; c++) begin
      @(negedge clk);
      if (seg_clk || !SEG_PEN) extra++;
    end
    Start = 1'b0;
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL held_single: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int frames, rises;
    bit prev_clk, prev_pen;
    frames = 0; rises = 0; prev_clk = 1'b0; prev_pen = SEG_PEN;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1 Start = ~Start;
      @(negedge clk);
      if (seg_clk && !prev_clk) rises++;
      if (SEG_PEN && !prev_pen) frames++;
      prev_clk = seg_clk; prev_pen = SEG_PEN;
    end
    Start = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (seg_clk && !prev_clk) rises++;
      if (SEG_PEN && !prev_pen) frames++;
      prev_clk = seg_clk; prev_pen = SEG_PEN;
    end
    checks++;
    if (frames < 4 || rises !== 64 * frames) begin
      errors++; $display("FAIL back_to_back: got %0d frames %0d rises expected >=4 frames and 64 rises each", frames, rises);
    end
    $display("back_to_back: frames=%0d rises=%0d", frames, rises);
  endtask

  initial begin
    test_reset();
    test_fixed_patterns();
    test_random_frames();
    test_busy_start();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
